// File: rtl/store_request_unit_if.sv
// store_request_unit_if: pipeline store request, data-bus write channel and status pulses
interface store_request_unit_if #(parameter int ADDR_W = 32);
   logic              req_valid;
   logic              req_ready;
   logic [ADDR_W-1:0] req_addr;
   logic [31:0]       req_data;
   logic [1:0]        req_type;
   logic              dreq_valid;
   logic [ADDR_W-1:0] dreq_addr;
   logic [3:0]        dreq_strobe;
   logic [31:0]       dreq_data;
   logic              dresp_addr_ok;
   logic              dresp_data_ok;
   logic              done;
   logic              addr_err;
   logic [ADDR_W-1:0] bad_vaddr;
   modport slave (
      input  req_valid, req_addr, req_data, req_type, dresp_addr_ok, dresp_data_ok,
      output req_ready, dreq_valid, dreq_addr, dreq_strobe, dreq_data, done, addr_err, bad_vaddr
   );
   modport master (
      output req_valid, req_addr, req_data, req_type, dresp_addr_ok, dresp_data_ok,
      input  req_ready, dreq_valid, dreq_addr, dreq_strobe, dreq_data, done, addr_err, bad_vaddr
   );
endinterface

// File: rtl/store_request_unit.sv
// store_request_unit: aligns store data/strobes and runs the two-phase bus write handshake
module store_request_unit #(parameter int ADDR_W = 32) (
   input logic clk,
   input logic resetn,
   store_request_unit_if.slave bus
);
   typedef enum logic [1:0] {IDLE, ADDR, DATA, ERR} state_t;
   state_t state;
   logic word, half, mis;
   logic [3:0] strb;
   logic [31:0] wdata;
   assign word = bus.req_type == 2'b00;
   assign half = bus.req_type == 2'b01;
   assign mis = word ? |bus.req_addr[1:0] : half & bus.req_addr[0];
   assign strb = word ? 4'hf : half ? (bus.req_addr[1] ? 4'hc : 4'h3) : 4'h1 << bus.req_addr[1:0];
   assign wdata = word ? bus.req_data : half ? {2{bus.req_data[15:0]}} : {4{bus.req_data[7:0]}};
   assign bus.req_ready = state == IDLE;
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state <= IDLE;
         bus.dreq_valid <= 1'b0;
         bus.dreq_addr <= '0;
         bus.dreq_strobe <= '0;
         bus.dreq_data <= '0;
         bus.done <= 1'b0;
         bus.addr_err <= 1'b0;
         bus.bad_vaddr <= '0;
      end else begin
         bus.done <= 1'b0;
         bus.addr_err <= 1'b0;
         case (state)
            IDLE: if (bus.req_valid) begin
               if (mis) begin
                  state <= ERR;
                  bus.addr_err <= 1'b1;
                  bus.bad_vaddr <= bus.req_addr;
               end else begin
                  state <= ADDR;
                  bus.dreq_valid <= 1'b1;
                  bus.dreq_addr <= bus.req_addr;
                  bus.dreq_strobe <= strb;
                  bus.dreq_data <= wdata;
               end
            end
            // data_ok together with addr_ok completes the store without visiting DATA
            ADDR: if (bus.dresp_addr_ok) begin
               bus.dreq_valid <= 1'b0;
               state <= bus.dresp_data_ok ? IDLE : DATA;
               bus.done <= bus.dresp_data_ok;
            end
            DATA: if (bus.dresp_data_ok) begin
               state <= IDLE;
               bus.done <= 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
